// File: rtl/reg_file_cmd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_ctrl_pkg : shared types/constants for the register-file     |
// | command sequencer.                            Revision: 1.0          |
// +----------------------------------------------------------------------+
package reg_file_ctrl_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_ADDR = 4'd1,
    S_WR_DLO  = 4'd2,
    S_WR_DHI  = 4'd3,
    S_WR_EXEC = 4'd4,
    S_RD_ADDR = 4'd5,
    S_RD_EXEC = 4'd6,
    S_RD_WAIT = 4'd7,
    S_TX_LO   = 4'd8,
    S_TX_HI   = 4'd9
  } state_t;

  // States in which a partially received frame is waiting for its next byte.
  function automatic logic is_frame_wait(state_t s);
    return (s == S_WR_ADDR) || (s == S_WR_DLO) || (s == S_WR_DHI) || (s == S_RD_ADDR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_cmd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_cmd_ctrl_if : RX / TX / register-file port bundle.          |
// |                                               Revision: 1.0          |
// +----------------------------------------------------------------------+
interface reg_file_cmd_ctrl_if;
  import reg_file_ctrl_pkg::*;

  logic [7:0]        RX_Data;
  logic              RX_Valid;
  logic [DATA_W-1:0] RF_RdData;
  logic [ADDR_W-1:0] RF_Address;
  logic [DATA_W-1:0] RF_WrData;
  logic              RF_WrEn;
  logic              RF_RdEn;
  logic [7:0]        TX_Data;
  logic              TX_Valid;
  logic              TX_Ready;
  logic              Busy;
  logic              Frame_Err;

  modport master (
    input  RX_Data, RX_Valid, RF_RdData, TX_Ready,
    output RF_Address, RF_WrData, RF_WrEn, RF_RdEn, TX_Data, TX_Valid, Busy, Frame_Err
  );

  modport slave (
    output RX_Data, RX_Valid, RF_RdData, TX_Ready,
    input  RF_Address, RF_WrData, RF_WrEn, RF_RdEn, TX_Data, TX_Valid, Busy, Frame_Err
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_cmd_ctrl_frame_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_timeout : down-counter that flags CYCLES idle cycles.          |
// |                                               Revision: 1.0          |
// +----------------------------------------------------------------------+
module frame_timeout #(
  parameter int CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = LOAD;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= LOAD;
    else      cnt_q <= cnt_d;
  end

  // A clear in the expiring cycle (a byte arrived) wins over the timeout.
  assign expire = en && !clr && (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/reg_file_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_cmd_ctrl : parses RX byte frames into register-file         |
// | accesses and returns read data on TX. Option: REGFILE_CTRL_TIMEOUT_EN|
// |                                               Revision: 1.0          |
// +----------------------------------------------------------------------+
module reg_file_cmd_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  reg_file_cmd_ctrl_if.master bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              frame_err_q, frame_err_d;
  logic              w_timeout;
  logic              w_wait;

  assign w_wait = is_frame_wait(state_q);

`ifdef REGFILE_CTRL_TIMEOUT_EN
  frame_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_frame_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (!w_wait || bus.RX_Valid),
    .en     (w_wait),
    .expire (w_timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hold_d      = hold_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.RX_Valid) begin
        if (bus.RX_Data == CMD_WR)      state_d = S_WR_ADDR;
        else if (bus.RX_Data == CMD_RD) state_d = S_RD_ADDR;
        else                            frame_err_d = 1'b1;
      end
      S_WR_ADDR, S_RD_ADDR: begin
        if (bus.RX_Valid) begin
          addr_d = bus.RX_Data[ADDR_W-1:0];
          if (bus.RX_Data[7:ADDR_W] != '0) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else if (state_q == S_WR_ADDR) begin
            state_d = S_WR_DLO;
          end else begin
            rd_en_d = 1'b1;
            state_d = S_RD_EXEC;
          end
        end else if (w_timeout) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WR_DLO, S_WR_DHI: begin
        if (bus.RX_Valid) begin
          if (state_q == S_WR_DLO) begin
            wdata_d[7:0] = bus.RX_Data;
            state_d      = S_WR_DHI;
          end else begin
            wdata_d[15:8] = bus.RX_Data;
            wr_en_d       = 1'b1;
            state_d       = S_WR_EXEC;
          end
        end else if (w_timeout) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      // Busy states: any incoming byte is discarded and flagged.
      S_WR_EXEC: begin
        frame_err_d = bus.RX_Valid;
        state_d     = S_IDLE;
      end
      S_RD_EXEC: begin
        frame_err_d = bus.RX_Valid;
        state_d     = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        frame_err_d = bus.RX_Valid;
        hold_d      = bus.RF_RdData;
        state_d     = S_TX_LO;
      end
      S_TX_LO: begin
        frame_err_d = bus.RX_Valid;
        if (bus.TX_Ready) state_d = S_TX_HI;
      end
      S_TX_HI: begin
        frame_err_d = bus.RX_Valid;
        if (bus.TX_Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      hold_q      <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.RF_Address = addr_q;
  assign bus.RF_WrData  = wdata_q;
  assign bus.RF_WrEn    = wr_en_q;
  assign bus.RF_RdEn    = rd_en_q;
  assign bus.Frame_Err  = frame_err_q;
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.TX_Valid   = (state_q == S_TX_LO) || (state_q == S_TX_HI);
  assign bus.TX_Data    = (state_q == S_TX_LO) ? hold_q[7:0]  :
                          (state_q == S_TX_HI) ? hold_q[15:8] : 8'h00;
endmodule
`default_nettype wire

// File: tb/tb_reg_file_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file_cmd_ctrl : directed self-checking bench with a simple    |
// | 8x16 register-file model.                     Revision: 1.0          |
// +----------------------------------------------------------------------+
module tb_reg_file_cmd_ctrl;
  logic CLK;
  logic RST;
  int   errors;
  int   checks;
  int   wr_count;
  logic both_seen;
  logic [15:0] mem [8];

  reg_file_cmd_ctrl_if bus();

  reg_file_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register-file model: read data appears one cycle after RF_RdEn.
  always @(posedge CLK) begin
    if (bus.RF_WrEn) mem[bus.RF_Address] <= bus.RF_WrData;
    if (bus.RF_RdEn) bus.RF_RdData <= mem[bus.RF_Address];
    if (bus.RF_WrEn) wr_count <= wr_count + 1;
    if (bus.RF_WrEn && bus.RF_RdEn) both_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_Data  = b;
    bus.RX_Valid = 1'b1;
    tick();
    bus.RX_Valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({bus.RF_Address, bus.RF_WrData, bus.RF_WrEn, bus.RF_RdEn} !== 21'd0) begin
      errors++;
      $display("FAIL reset_rf: got addr=%h wd=%h we=%b re=%b want all 0",
               bus.RF_Address, bus.RF_WrData, bus.RF_WrEn, bus.RF_RdEn);
    end
    checks++;
    if ({bus.TX_Data, bus.TX_Valid, bus.Busy, bus.Frame_Err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_out: got txd=%h txv=%b busy=%b ferr=%b want all 0",
               bus.TX_Data, bus.TX_Valid, bus.Busy, bus.Frame_Err);
    end
    RST = 1'b1;
    tick();
    send_byte(8'hAA);
    send_byte(8'h05);
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++; $display("FAIL midframe_busy: got %b want 1", bus.Busy);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({bus.Busy, bus.RF_Address} !== 4'd0) begin
      errors++;
      $display("FAIL midframe_reset: got busy=%b addr=%h want 0/0", bus.Busy, bus.RF_Address);
    end
    tick();
    RST = 1'b1;
    repeat (4) tick();
    checks++;
    if (wr_count !== 0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_nowrite: got writes=%0d busy=%b want 0/0", wr_count, bus.Busy);
    end
  endtask

  task automatic test_write_read();
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h34);
    send_byte(8'h12);
    checks++;
    if ({bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData} !== {1'b1, 1'b0, 3'd5, 16'h1234}) begin
      errors++;
      $display("FAIL wr_exec: got we=%b re=%b addr=%h wd=%h want 1/0/5/1234",
               bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData);
    end
    tick();
    checks++;
    if ({bus.RF_WrEn, bus.Busy} !== 2'b00 || mem[5] !== 16'h1234 || wr_count !== 1) begin
      errors++;
      $display("FAIL wr_done: got we=%b busy=%b mem5=%h writes=%0d want 0/0/1234/1",
               bus.RF_WrEn, bus.Busy, mem[5], wr_count);
    end
    send_byte(8'hBB);
    send_byte(8'h05);
    checks++;
    if ({bus.RF_RdEn, bus.RF_WrEn, bus.TX_Valid} !== 3'b100) begin
      errors++;
      $display("FAIL rd_exec: got re=%b we=%b txv=%b want 1/0/0", bus.RF_RdEn, bus.RF_WrEn, bus.TX_Valid);
    end
    tick();
    checks++;
    if ({bus.RF_RdEn, bus.TX_Valid, bus.Busy} !== 3'b001) begin
      errors++;
      $display("FAIL rd_wait: got re=%b txv=%b busy=%b want 0/0/1", bus.RF_RdEn, bus.TX_Valid, bus.Busy);
    end
    tick();
    checks++;
    if ({bus.TX_Valid, bus.TX_Data} !== {1'b1, 8'h34}) begin
      errors++; $display("FAIL tx_lo: got v=%b d=%h want 1/34", bus.TX_Valid, bus.TX_Data);
    end
    tick();
    checks++;
    if ({bus.TX_Valid, bus.TX_Data} !== {1'b1, 8'h12}) begin
      errors++; $display("FAIL tx_hi: got v=%b d=%h want 1/12", bus.TX_Valid, bus.TX_Data);
    end
    tick();
    checks++;
    if ({bus.TX_Valid, bus.Busy} !== 2'b00) begin
      errors++; $display("FAIL rd_done: got txv=%b busy=%b want 0/0", bus.TX_Valid, bus.Busy);
    end
  endtask

  task automatic test_bad_frames();
    int w0;
    w0 = wr_count;
    send_byte(8'h3C);
    checks++;
    if ({bus.Frame_Err, bus.Busy} !== 2'b10) begin
      errors++; $display("FAIL bad_cmd: got ferr=%b busy=%b want 1/0", bus.Frame_Err, bus.Busy);
    end
    tick();
    checks++;
    if (bus.Frame_Err !== 1'b0) begin
      errors++; $display("FAIL bad_cmd_pulse: got ferr=%b want 0", bus.Frame_Err);
    end
    send_byte(8'hAA);
    send_byte(8'h09);
    checks++;
    if ({bus.Frame_Err, bus.Busy} !== 2'b10) begin
      errors++; $display("FAIL bad_addr: got ferr=%b busy=%b want 1/0", bus.Frame_Err, bus.Busy);
    end
    repeat (3) tick();
    checks++;
    if (wr_count !== w0 || bus.Frame_Err !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr_nowrite: got writes=%0d ferr=%b want %0d/0", wr_count, bus.Frame_Err, w0);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    bus.TX_Ready = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h05);
    tick();
    tick();
    repeat (20) begin
      if ({bus.TX_Valid, bus.TX_Data} !== {1'b1, 8'h34}) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || {bus.TX_Valid, bus.TX_Data} !== {1'b1, 8'h34}) begin
      errors++;
      $display("FAIL tx_hold: got %0d unstable cycles, now v=%b d=%h want 0 and 1/34",
               bad, bus.TX_Valid, bus.TX_Data);
    end
    bus.TX_Ready = 1'b1;
    tick();
    checks++;
    if ({bus.TX_Valid, bus.TX_Data} !== {1'b1, 8'h12}) begin
      errors++; $display("FAIL tx_hold_hi: got v=%b d=%h want 1/12", bus.TX_Valid, bus.TX_Data);
    end
    tick();
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++; $display("FAIL tx_hold_done: got busy=%b want 0", bus.Busy);
    end
  endtask

  task automatic test_overrun();
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'hCD);
    send_byte(8'hAB);
    tick();
    send_byte(8'hBB);
    send_byte(8'h02);
    tick();
    send_byte(8'hAA);
    checks++;
    if ({bus.Frame_Err, bus.TX_Valid, bus.TX_Data} !== {1'b1, 1'b1, 8'hCD}) begin
      errors++;
      $display("FAIL overrun_lo: got ferr=%b v=%b d=%h want 1/1/cd", bus.Frame_Err, bus.TX_Valid, bus.TX_Data);
    end
    tick();
    checks++;
    if ({bus.Frame_Err, bus.TX_Data} !== {1'b0, 8'hAB}) begin
      errors++; $display("FAIL overrun_hi: got ferr=%b d=%h want 0/ab", bus.Frame_Err, bus.TX_Data);
    end
    tick();
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++; $display("FAIL overrun_done: got busy=%b want 0", bus.Busy);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h78);
    send_byte(8'h56);
    tick();
    send_byte(8'hBB);
    checks++;
    if ({bus.Busy, bus.Frame_Err, mem[3]} !== {1'b1, 1'b0, 16'h5678}) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b ferr=%b mem3=%h want 1/0/5678", bus.Busy, bus.Frame_Err, mem[3]);
    end
    send_byte(8'h03);
    tick();
    tick();
    checks++;
    if (bus.TX_Data !== 8'h78) begin
      errors++; $display("FAIL b2b_lo: got %h want 78", bus.TX_Data);
    end
    tick();
    checks++;
    if (bus.TX_Data !== 8'h56) begin
      errors++; $display("FAIL b2b_hi: got %h want 56", bus.TX_Data);
    end
    tick();
  endtask

`ifdef REGFILE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int w0;
    w0 = wr_count;
    send_byte(8'hAA);
    repeat (15) tick();
    checks++;
    if ({bus.Busy, bus.Frame_Err} !== 2'b10) begin
      errors++; $display("FAIL to_early: got busy=%b ferr=%b want 1/0", bus.Busy, bus.Frame_Err);
    end
    tick();
    checks++;
    if ({bus.Busy, bus.Frame_Err} !== 2'b01) begin
      errors++; $display("FAIL to_fire: got busy=%b ferr=%b want 0/1", bus.Busy, bus.Frame_Err);
    end
    tick();
    send_byte(8'hAA);
    repeat (15) tick();
    send_byte(8'h05);
    checks++;
    if ({bus.Busy, bus.Frame_Err, bus.RF_Address} !== {1'b1, 1'b0, 3'd5}) begin
      errors++;
      $display("FAIL to_edge_accept: got busy=%b ferr=%b addr=%h want 1/0/5", bus.Busy, bus.Frame_Err, bus.RF_Address);
    end
    repeat (16) tick();
    checks++;
    if ({bus.Busy, bus.Frame_Err} !== 2'b01 || wr_count !== w0) begin
      errors++;
      $display("FAIL to_dlo: got busy=%b ferr=%b writes=%0d want 0/1/%0d", bus.Busy, bus.Frame_Err, wr_count, w0);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    errors       = 0;
    checks       = 0;
    wr_count     = 0;
    both_seen    = 1'b0;
    RST          = 1'b0;
    bus.RX_Data  = 8'h00;
    bus.RX_Valid = 1'b0;
    bus.TX_Ready = 1'b1;
    test_reset();
    test_write_read();
    test_bad_frames();
    test_backpressure();
    test_overrun();
    test_back_to_back();
`ifdef REGFILE_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (both_seen !== 1'b0) begin
      errors++; $display("FAIL wr_rd_exclusive: got overlap=%b want 0", both_seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
